// File: rtl/stack_pointer_unit.sv
// Stack pointer unit: independent main and return stack pointers with
// separate depth counters, sticky overflow/underflow flags and optional
// high-water-mark tracking.
// Optional feature macro: STACK_HWM_EN (enables MSMaxDepth/RSMaxDepth tracking).

module stack_channel #(
    parameter logic [15:0] BASE  = 16'hFFFF,
    parameter int          LIMIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pop,
    input  logic        write,
    input  logic        reg_reset,
    output logic [15:0] ptr,
    output logic [15:0] ptr_plus1,
    output logic [15:0] depth,
    output logic        overflow,
    output logic        underflow,
    output logic [15:0] max_depth
);

    localparam logic [15:0] LIMIT_W = 16'(LIMIT);

    logic [15:0] ptr_next;
    logic [15:0] depth_next;
    logic        overflow_next;
    logic        underflow_next;
    logic        faulted;

    assign faulted   = overflow | underflow;
    assign ptr_plus1 = ptr + 16'd1;

    // Work out the single move requested this cycle; a faulted stack freezes
    // until it is reloaded, and illegal moves only raise the matching flag.
    always_comb begin
        ptr_next       = ptr;
        depth_next     = depth;
        overflow_next  = overflow;
        underflow_next = underflow;
        if (write && !faulted) begin
            if (pop) begin
                if (depth == 16'd0) begin
                    underflow_next = 1'b1;
                end else begin
                    ptr_next   = ptr + 16'd1;
                    depth_next = depth - 16'd1;
                end
            end else begin
                if (depth == LIMIT_W) begin
                    overflow_next = 1'b1;
                end else begin
                    ptr_next   = ptr - 16'd1;
                    depth_next = depth + 16'd1;
                end
            end
        end
    end

    // Pointer, depth and flag registers; rst beats the per-stack reload,
    // which in turn beats any move.
    always_ff @(posedge clk) begin
        if (rst || reg_reset) begin
            ptr       <= BASE;
            depth     <= 16'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ptr       <= ptr_next;
            depth     <= depth_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

`ifdef STACK_HWM_EN
    logic [15:0] hwm;

    // High-water mark follows the registered depth one cycle later and only
    // the global reset clears it, so a stack reload keeps the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm <= 16'd0;
        end else if (depth > hwm) begin
            hwm <= depth;
        end
    end

    assign max_depth = hwm;
`else
    assign max_depth = 16'd0;
`endif

endmodule

module stack_pointer_unit #(
    parameter logic [15:0] MS_BASE  = 16'h7FFF,
    parameter int          MS_LIMIT = 256,
    parameter logic [15:0] RS_BASE  = 16'h6FFF,
    parameter int          RS_LIMIT = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MSPop,
    input  logic        RSPop,
    input  logic        MSPWrite,
    input  logic        RSPWrite,
    input  logic        MSPRegReset,
    input  logic        RSPRegReset,
    output logic [15:0] MSP,
    output logic [15:0] RSP,
    output logic [15:0] MSPPlus1,
    output logic [15:0] RSPPlus1,
    output logic [15:0] MSDepth,
    output logic [15:0] RSDepth,
    output logic        MSOverflow,
    output logic        MSUnderflow,
    output logic        RSOverflow,
    output logic        RSUnderflow,
    output logic        StackFault,
    output logic [15:0] MSMaxDepth,
    output logic [15:0] RSMaxDepth
);

    stack_channel #(
        .BASE  (MS_BASE),
        .LIMIT (MS_LIMIT)
    ) main_stack (
        .clk       (clk),
        .rst       (rst),
        .pop       (MSPop),
        .write     (MSPWrite),
        .reg_reset (MSPRegReset),
        .ptr       (MSP),
        .ptr_plus1 (MSPPlus1),
        .depth     (MSDepth),
        .overflow  (MSOverflow),
        .underflow (MSUnderflow),
        .max_depth (MSMaxDepth)
    );

    stack_channel #(
        .BASE  (RS_BASE),
        .LIMIT (RS_LIMIT)
    ) return_stack (
        .clk       (clk),
        .rst       (rst),
        .pop       (RSPop),
        .write     (RSPWrite),
        .reg_reset (RSPRegReset),
        .ptr       (RSP),
        .ptr_plus1 (RSPPlus1),
        .depth     (RSDepth),
        .overflow  (RSOverflow),
        .underflow (RSUnderflow),
        .max_depth (RSMaxDepth)
    );

    assign StackFault = MSOverflow | MSUnderflow | RSOverflow | RSUnderflow;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Testbench for stack_pointer_unit: directed sequences with literal
// expectations followed by randomized traffic checked against a depth-based
// behavioural model every cycle. Honours STACK_HWM_EN like the design.

module tb_stack_pointer_unit;

    localparam logic [15:0] MS_BASE  = 16'h7FFF;
    localparam int          MS_LIMIT = 256;
    localparam logic [15:0] RS_BASE  = 16'h6FFF;
    localparam int          RS_LIMIT = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ms_pop = 1'b0, rs_pop = 1'b0;
    logic        ms_write = 1'b0, rs_write = 1'b0;
    logic        ms_rr = 1'b0, rs_rr = 1'b0;
    logic [15:0] msp, rsp, msp_plus1, rsp_plus1, ms_depth, rs_depth;
    logic        ms_ovf, ms_unf, rs_ovf, rs_unf, stack_fault;
    logic [15:0] ms_max, rs_max;

    int checks = 0;
    int passes = 0;
    bit compare_en = 1'b0;

    // Behavioural model state: only depths, flags and marks are kept; the
    // expected pointers follow from base minus depth.
    int m_ms_depth = 0, m_rs_depth = 0;
    bit m_ms_ovf = 0, m_ms_unf = 0, m_rs_ovf = 0, m_rs_unf = 0;
    int m_ms_hwm = 0, m_rs_hwm = 0;

    stack_pointer_unit #(
        .MS_BASE  (MS_BASE),
        .MS_LIMIT (MS_LIMIT),
        .RS_BASE  (RS_BASE),
        .RS_LIMIT (RS_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MSPop       (ms_pop),
        .RSPop       (rs_pop),
        .MSPWrite    (ms_write),
        .RSPWrite    (rs_write),
        .MSPRegReset (ms_rr),
        .RSPRegReset (rs_rr),
        .MSP         (msp),
        .RSP         (rsp),
        .MSPPlus1    (msp_plus1),
        .RSPPlus1    (rsp_plus1),
        .MSDepth     (ms_depth),
        .RSDepth     (rs_depth),
        .MSOverflow  (ms_ovf),
        .MSUnderflow (ms_unf),
        .RSOverflow  (rs_ovf),
        .RSUnderflow (rs_unf),
        .StackFault  (stack_fault),
        .MSMaxDepth  (ms_max),
        .RSMaxDepth  (rs_max)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelStack(input bit wr, input bit pop, input bit rr, input int limit,
                              inout int depth, inout bit ovf, inout bit unf);
        if (rr) begin
            depth = 0;
            ovf   = 0;
            unf   = 0;
        end else if (wr && !(ovf || unf)) begin
            if (pop) begin
                if (depth == 0) unf = 1;
                else depth--;
            end else begin
                if (depth == limit) ovf = 1;
                else depth++;
            end
        end
    endtask

    // Reference model advances on each clock edge from the inputs present there.
    always @(posedge clk) begin
        if (rst) begin
            m_ms_depth = 0; m_rs_depth = 0;
            m_ms_ovf = 0; m_ms_unf = 0; m_rs_ovf = 0; m_rs_unf = 0;
            m_ms_hwm = 0; m_rs_hwm = 0;
        end else begin
            if (m_ms_depth > m_ms_hwm) m_ms_hwm = m_ms_depth;
            if (m_rs_depth > m_rs_hwm) m_rs_hwm = m_rs_depth;
            modelStack(ms_write, ms_pop, ms_rr, MS_LIMIT, m_ms_depth, m_ms_ovf, m_ms_unf);
            modelStack(rs_write, rs_pop, rs_rr, RS_LIMIT, m_rs_depth, m_rs_ovf, m_rs_unf);
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        if (compare_en) begin
            logic [15:0] e_msp, e_rsp, e_ms_max, e_rs_max;
            e_msp = 16'(int'(MS_BASE) - m_ms_depth);
            e_rsp = 16'(int'(RS_BASE) - m_rs_depth);
`ifdef STACK_HWM_EN
            e_ms_max = 16'(m_ms_hwm);
            e_rs_max = 16'(m_rs_hwm);
`else
            e_ms_max = 16'd0;
            e_rs_max = 16'd0;
`endif
            checkOutput("model_msp", msp, e_msp);
            checkOutput("model_msp_plus1", msp_plus1, e_msp + 16'd1);
            checkOutput("model_ms_depth", ms_depth, 16'(m_ms_depth));
            checkOutput("model_ms_ovf", {15'd0, ms_ovf}, {15'd0, m_ms_ovf});
            checkOutput("model_ms_unf", {15'd0, ms_unf}, {15'd0, m_ms_unf});
            checkOutput("model_rsp", rsp, e_rsp);
            checkOutput("model_rsp_plus1", rsp_plus1, e_rsp + 16'd1);
            checkOutput("model_rs_depth", rs_depth, 16'(m_rs_depth));
            checkOutput("model_rs_ovf", {15'd0, rs_ovf}, {15'd0, m_rs_ovf});
            checkOutput("model_rs_unf", {15'd0, rs_unf}, {15'd0, m_rs_unf});
            checkOutput("model_fault", {15'd0, stack_fault},
                        {15'd0, m_ms_ovf | m_ms_unf | m_rs_ovf | m_rs_unf});
            checkOutput("model_ms_max", ms_max, e_ms_max);
            checkOutput("model_rs_max", rs_max, e_rs_max);
        end
    end

    // One clock of stimulus, then inputs return to idle just after the edge.
    task automatic applyStimulus(input bit r, input bit mw, input bit mp, input bit mr,
                                 input bit rw, input bit rp, input bit rr);
        rst = r; ms_write = mw; ms_pop = mp; ms_rr = mr;
        rs_write = rw; rs_pop = rp; rs_rr = rr;
        @(posedge clk);
        #1;
        rst = 0; ms_write = 0; ms_pop = 0; ms_rr = 0;
        rs_write = 0; rs_pop = 0; rs_rr = 0;
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        compare_en = 1'b1;
        checkOutput("reset_msp", msp, 16'h7FFF);
        checkOutput("reset_rsp", rsp, 16'h6FFF);
        checkOutput("reset_ms_depth", ms_depth, 16'd0);
        checkOutput("reset_fault", {15'd0, stack_fault}, 16'd0);

        // Three main-stack pushes.
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("push3_msp", msp, 16'h7FFC);
        checkOutput("push3_depth", ms_depth, 16'd3);
        checkOutput("push3_plus1", msp_plus1, 16'h7FFD);
        checkOutput("push3_fault", {15'd0, stack_fault}, 16'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        // Underflow, frozen stack, reload clears it.
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("unf_flag", {15'd0, ms_unf}, 16'd1);
        checkOutput("unf_fault", {15'd0, stack_fault}, 16'd1);
        checkOutput("unf_msp", msp, 16'h7FFF);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("unf_push_ignored", msp, 16'h7FFF);
        checkOutput("unf_push_depth", ms_depth, 16'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("unf_cleared", {15'd0, ms_unf}, 16'd0);

        // Fill the return stack past its limit.
        repeat (128) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("rs128_ovf", {15'd0, rs_ovf}, 16'd0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("rs129_depth", rs_depth, 16'd128);
        checkOutput("rs129_rsp", rsp, 16'h6F7F);
        checkOutput("rs129_ovf", {15'd0, rs_ovf}, 16'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Simultaneous operations on both stacks.
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 1, 0);
        checkOutput("dual_ms_depth", ms_depth, 16'd1);
        checkOutput("dual_rs_depth", rs_depth, 16'd1);

        // Reload beats write; rst beats everything.
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        checkOutput("rr_prio_msp", msp, 16'h7FFF);
        checkOutput("rr_prio_depth", ms_depth, 16'd0);
        applyStimulus(1, 1, 0, 0, 1, 0, 0);
        checkOutput("rst_prio_msp", msp, 16'h7FFF);
        checkOutput("rst_prio_rsp", rsp, 16'h6FFF);
        checkOutput("rst_prio_rs_depth", rs_depth, 16'd0);

        // High-water mark survives a reload.
        repeat (5) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
`ifdef STACK_HWM_EN
        checkOutput("hwm_ms", ms_max, 16'd5);
`else
        checkOutput("hwm_ms", ms_max, 16'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40,
                          $urandom_range(0, 99) < 3);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stack_pointer_unit.md
STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

Interface
REQ-001 SHALL have parameter MS_BASE, default 16'h7FFF, main-stack empty pointer value.
REQ-002 SHALL have parameter MS_LIMIT, default 256, max main-stack entries.
REQ-003 SHALL have parameter RS_BASE, default 16'h6FFF, return-stack empty pointer value.
REQ-004 SHALL have parameter RS_LIMIT, default 128, max return-stack entries.
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on posedge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports MSPop and RSPop, input, 1 each, direction: 1=pop, 0=push.
REQ-008 SHALL have ports MSPWrite and RSPWrite, input, 1 each, enable pointer update this cycle.
REQ-009 SHALL have ports MSPRegReset and RSPRegReset, input, 1 each, reload pointer to base.
REQ-010 SHALL have ports MSP and RSP, output, 16 each, current top-of-stack address.
REQ-011 SHALL have ports MSPPlus1 and RSPPlus1, output, 16 each, second-entry address (pointer+1, mod 2^16).
REQ-012 SHALL have ports MSDepth and RSDepth, output, 16 each, current entry count.
REQ-013 SHALL have ports MSOverflow, MSUnderflow, RSOverflow and RSUnderflow, output, 1 each, sticky fault flags.
REQ-014 SHALL have port StackFault, output, 1, OR of all four fault flags.
REQ-015 SHALL have ports MSMaxDepth and RSMaxDepth, output, 16 each, high-water marks (see Configuration).

Function
REQ-016 Stacks SHALL grow downward: push gives P-1 and depth+1; pop gives P+1 and depth-1.
REQ-017 Updates SHALL be registered; new MSP/RSP/Depth values SHALL be visible the cycle after the Write-qualified edge.
REQ-018 The Write inputs SHALL act as level enables; each cycle with Write=1 SHALL cause one move.
REQ-019 With Write=0 and RegReset=0, pointer and depth SHALL hold.
REQ-020 RegReset=1 SHALL load the base, zero the depth and clear both fault flags of that stack only.
REQ-021 RegReset SHALL take priority over Write in the same cycle.
REQ-022 A pop at depth 0 SHALL set the Underflow flag, and the pointer and depth SHALL hold.
REQ-023 A push at depth==LIMIT SHALL set the Overflow flag, and the pointer and depth SHALL hold.
REQ-024 While any flag of a stack is set, further Write moves on that stack SHALL be ignored until RegReset or rst.
REQ-025 The main and return stacks SHALL be fully independent; simultaneous operations on both SHALL both take effect.
REQ-026 Depth SHALL be a separate counter, never derived by subtraction, and SHALL always equal base minus pointer.
REQ-027 The Plus1 outputs SHALL be combinational from the pointer registers.

Reset
REQ-028 rst=1 at a posedge SHALL set MSP=MS_BASE, RSP=RS_BASE, both depths=0, all faults=0 and both MaxDepth outputs=0.
REQ-029 rst SHALL override RegReset and Write; rst asserted mid-sequence SHALL abandon all pending moves with no partial update.

Configuration
REQ-030 Macro STACK_HWM_EN defined: MSMaxDepth/RSMaxDepth SHALL register the max depth reached since rst, updated the cycle after the depth increases.
REQ-031 With STACK_HWM_EN defined, RegReset SHALL NOT clear the high-water marks.
REQ-032 Macro STACK_HWM_EN undefined: both MaxDepth ports SHALL remain present and tied to 0, with no tracking registers.

Verification
REQ-033 rst, then 3 MS pushes -> MSP=16'h7FFC, MSDepth=3, MSPPlus1=16'h7FFD, no fault.
REQ-034 From reset, MS pop -> MSUnderflow=1, StackFault=1, MSP=16'h7FFF; a following push is ignored; MSPRegReset clears the flag.
REQ-035 129 RS pushes -> RSDepth=128, RSP=16'h6F7F, RSOverflow=1 after the 129th push.
REQ-036 Same cycle: MS push, RS pop at RS depth 2 -> MSDepth+1 and RSDepth=1 on the next cycle.
REQ-037 MSPRegReset with MSPWrite in the same cycle -> MSP=16'h7FFF, MSDepth=0; rst with pushes pending -> all outputs at reset values.
REQ-038 With STACK_HWM_EN: push 5, pop 3, RegReset -> MSMaxDepth=5; without the macro -> MSMaxDepth=0.
